uart_bench_agent: RTL

- Parametrised, synthesizable UART agent for system-level benches and FPGA loopback rigs.
- Drives the DUT serial input and captures the DUT serial output, with independent TX/RX FIFOs and a valid/ready byte interface on the host side.
- Generalises the fixed, tied-off serial stimulus of the current top-level bench: configurable clock, baud, frame format and buffer depth, plus error reporting.

---
 rtl/uart_bench_agent.sv | 279 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_bench_agent.sv
// UART bench agent: TX/RX FIFOs, valid/ready host side, sticky RX error flags.
// Optional even parity bit enabled by defining UART_BENCH_AGENT_PARITY_EN.
module uart_bench_agent #(
  parameter int CLK_HZ     = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk_50M,
  input  logic                              k_resetb,
  input  logic                              uart_rx_i,
  output logic                              uart_tx_o,
  input  logic [DATA_BITS-1:0]              tx_data_i,
  input  logic                              tx_valid_i,
  output logic                              tx_ready_o,
  output logic                              tx_busy_o,
  output logic [DATA_BITS-1:0]              rx_data_o,
  output logic                              rx_valid_o,
  input  logic                              rx_ready_i,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   rx_level_o,
  output logic                              rx_overflow_o,
  output logic                              rx_frame_err_o,
  output logic                              rx_parity_err_o,
  input  logic                              clear_err_i
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = $clog2(FIFO_DEPTH+1);
  localparam int CW  = $clog2(STOP_BITS*CPB+1);
  localparam int BW  = $clog2(DATA_BITS+1);
  localparam logic [CW-1:0] BIT_END  = CW'(CPB-1);
  localparam logic [CW-1:0] HALF_END = CW'(CPB/2-1);
  localparam logic [CW-1:0] STOP_END = CW'(STOP_BITS*CPB-1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS-1);
  localparam logic [LW-1:0] FULL     = LW'(FIFO_DEPTH);

  generate
    if (CPB < 4) begin : g_cpb_chk
      $error("CLK_HZ/BAUD must be at least 4");
    end
  endgenerate

  typedef enum logic [2:0] {
    T_IDLE, T_START, T_DATA,
`ifdef UART_BENCH_AGENT_PARITY_EN
    T_PAR,
`endif
    T_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    R_IDLE, R_START, R_DATA,
`ifdef UART_BENCH_AGENT_PARITY_EN
    R_PAR,
`endif
    R_STOP, R_WAIT
  } rx_state_t;

  logic [DATA_BITS-1:0] tmem [FIFO_DEPTH];
  logic [AW-1:0]        twr, trd;
  logic [LW-1:0]        tcnt;
  logic                 tpush, tpop;
  tx_state_t            ts;
  logic [CW-1:0]        tc;
  logic [BW-1:0]        tb;
  logic [DATA_BITS-1:0] tsh;
  logic                 line;

  assign tx_ready_o = tcnt != FULL;
  assign tpush      = tx_valid_i && tx_ready_o;
  assign tpop       = (tcnt != '0) &&
                      ((ts == T_IDLE) || (ts == T_STOP && tc == STOP_END));
  assign tx_busy_o  = (tcnt != '0) || (ts != T_IDLE);
  assign uart_tx_o  = line;

  always_ff @(posedge clk_50M)
    if (tpush) tmem[twr] <= tx_data_i;

  always_ff @(posedge clk_50M)
    if (k_resetb) begin
      twr  <= '0;
      trd  <= '0;
      tcnt <= '0;
    end else begin
      if (tpush) twr <= twr + 1'b1;
      if (tpop)  trd <= trd + 1'b1;
      tcnt <= tcnt + LW'(tpush) - LW'(tpop);
    end

`ifdef UART_BENCH_AGENT_PARITY_EN
  logic tpar;
`endif

  always_ff @(posedge clk_50M)
    if (k_resetb) begin
      ts   <= T_IDLE;
      tc   <= '0;
      tb   <= '0;
      tsh  <= '0;
      line <= 1'b1;
`ifdef UART_BENCH_AGENT_PARITY_EN
      tpar <= 1'b0;
`endif
    end else begin
      unique case (ts)
        T_IDLE:
          if (tpop) begin
            tsh  <= tmem[trd];
`ifdef UART_BENCH_AGENT_PARITY_EN
            tpar <= ^tmem[trd];
`endif
            line <= 1'b0;
            tc   <= '0;
            ts   <= T_START;
          end
        T_START:
          if (tc == BIT_END) begin
            tc   <= '0;
            tb   <= '0;
            line <= tsh[0];
            ts   <= T_DATA;
          end else tc <= tc + 1'b1;
        T_DATA:
          if (tc == BIT_END) begin
            tc  <= '0;
            tsh <= tsh >> 1;
            tb  <= tb + 1'b1;
            if (tb == LAST_BIT) begin
`ifdef UART_BENCH_AGENT_PARITY_EN
              line <= tpar;
              ts   <= T_PAR;
`else
              line <= 1'b1;
              ts   <= T_STOP;
`endif
            end else line <= tsh[1];
          end else tc <= tc + 1'b1;
`ifdef UART_BENCH_AGENT_PARITY_EN
        T_PAR:
          if (tc == BIT_END) begin
            tc   <= '0;
            line <= 1'b1;
            ts   <= T_STOP;
          end else tc <= tc + 1'b1;
`endif
        T_STOP:
          if (tc == STOP_END) begin
            tc <= '0;
            // chain straight into the next start bit when data is waiting
            if (tpop) begin
              tsh  <= tmem[trd];
`ifdef UART_BENCH_AGENT_PARITY_EN
              tpar <= ^tmem[trd];
`endif
              line <= 1'b0;
              ts   <= T_START;
            end else ts <= T_IDLE;
          end else tc <= tc + 1'b1;
        default: ts <= T_IDLE;
      endcase
    end

  logic [1:0]           sync;
  logic                 rxs;
  rx_state_t            rs;
  logic [CW-1:0]        rc;
  logic [BW-1:0]        rb;
  logic [DATA_BITS-1:0] rsh;
  logic                 rdone, rpush, rpop, racc, ovf_set, fe_set;
  logic [DATA_BITS-1:0] rmem [FIFO_DEPTH];
  logic [AW-1:0]        rwr, rrd;
  logic [LW-1:0]        rcnt;

  always_ff @(posedge clk_50M)
    if (k_resetb) sync <= 2'b11;
    else          sync <= {sync[0], uart_rx_i};

  assign rxs   = sync[1];
  assign rdone = (rs == R_STOP) && (rc == BIT_END);
`ifdef UART_BENCH_AGENT_PARITY_EN
  logic rpbad, pe_set;
  assign pe_set = (rs == R_PAR) && (rc == BIT_END) && (rxs != ^rsh);
  assign rpush  = rdone && rxs && !rpbad;
`else
  assign rpush  = rdone && rxs;
`endif
  assign fe_set  = rdone && !rxs;
  assign rpop    = rx_valid_o && rx_ready_i;
  assign racc    = rpush && ((rcnt != FULL) || rpop);
  assign ovf_set = rpush && (rcnt == FULL) && !rpop;

  always_ff @(posedge clk_50M)
    if (k_resetb) begin
      rs  <= R_IDLE;
      rc  <= '0;
      rb  <= '0;
      rsh <= '0;
`ifdef UART_BENCH_AGENT_PARITY_EN
      rpbad <= 1'b0;
`endif
    end else begin
      unique case (rs)
        R_IDLE:
          if (!rxs) begin
            rc <= '0;
            rs <= R_START;
          end
        R_START:
          if (rc == HALF_END) begin
            rc <= '0;
            rb <= '0;
            rs <= rxs ? R_IDLE : R_DATA;
          end else rc <= rc + 1'b1;
        R_DATA:
          if (rc == BIT_END) begin
            rc  <= '0;
            rsh <= {rxs, rsh[DATA_BITS-1:1]};
            rb  <= rb + 1'b1;
`ifdef UART_BENCH_AGENT_PARITY_EN
            if (rb == LAST_BIT) rs <= R_PAR;
`else
            if (rb == LAST_BIT) rs <= R_STOP;
`endif
          end else rc <= rc + 1'b1;
`ifdef UART_BENCH_AGENT_PARITY_EN
        R_PAR:
          if (rc == BIT_END) begin
            rc    <= '0;
            rpbad <= rxs != ^rsh;
            rs    <= R_STOP;
          end else rc <= rc + 1'b1;
`endif
        R_STOP:
          if (rc == BIT_END) begin
            rc <= '0;
            rs <= rxs ? R_IDLE : R_WAIT;
          end else rc <= rc + 1'b1;
        R_WAIT:
          if (rxs) rs <= R_IDLE;
        default: rs <= R_IDLE;
      endcase
    end

  always_ff @(posedge clk_50M)
    if (racc) rmem[rwr] <= rsh;

  always_ff @(posedge clk_50M)
    if (k_resetb) begin
      rwr  <= '0;
      rrd  <= '0;
      rcnt <= '0;
    end else begin
      if (racc) rwr <= rwr + 1'b1;
      if (rpop) rrd <= rrd + 1'b1;
      rcnt <= rcnt + LW'(racc) - LW'(rpop);
    end

  assign rx_valid_o = rcnt != '0;
  assign rx_level_o = rcnt;
  assign rx_data_o  = rx_valid_o ? rmem[rrd] : '0;

  always_ff @(posedge clk_50M)
    if (k_resetb) begin
      rx_overflow_o  <= 1'b0;
      rx_frame_err_o <= 1'b0;
    end else begin
      rx_overflow_o  <= ovf_set | (rx_overflow_o & ~clear_err_i);
      rx_frame_err_o <= fe_set | (rx_frame_err_o & ~clear_err_i);
    end

`ifdef UART_BENCH_AGENT_PARITY_EN
  always_ff @(posedge clk_50M)
    if (k_resetb) rx_parity_err_o <= 1'b0;
    else rx_parity_err_o <= pe_set | (rx_parity_err_o & ~clear_err_i);
`else
  assign rx_parity_err_o = 1'b0;
`endif
endmodule
